// File: rtl/lc3b_pkg.sv
// LC-3b decode constants, payload types and the instruction-field decoder.
package lc3b_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned IMM5_W   = 5;

  localparam logic [OP_W-1:0] OP_BR   = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_LDB  = 4'h2;
  localparam logic [OP_W-1:0] OP_STB  = 4'h3;
  localparam logic [OP_W-1:0] OP_JSR  = 4'h4;
  localparam logic [OP_W-1:0] OP_AND  = 4'h5;
  localparam logic [OP_W-1:0] OP_LDW  = 4'h6;
  localparam logic [OP_W-1:0] OP_STW  = 4'h7;
  localparam logic [OP_W-1:0] OP_RTI  = 4'h8;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
  localparam logic [OP_W-1:0] OP_SHF  = 4'hD;
  localparam logic [OP_W-1:0] OP_LEA  = 4'hE;
  localparam logic [OP_W-1:0] OP_TRAP = 4'hF;

  localparam logic [REG_W-1:0] LINK_REG = 3'd7;

  // Register usage of one instruction; unused fields are forced to zero.
  typedef struct packed {
    logic             sr1_used;
    logic             sr2_used;
    logic             dr_we;
    logic [REG_W-1:0] sr1;
    logic [REG_W-1:0] sr2;
    logic [REG_W-1:0] dr;
  } dec_t;

  // Payload handed to execute.
  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_W-1:0]  dr;
    logic              dr_we;
  } issue_t;

  function automatic dec_t decode(input logic [DATA_W-1:0] ir);
    dec_t d;
    d = '0;
    case (ir[15:12])
      OP_ADD, OP_AND, OP_XOR: begin
        d.sr1_used = 1'b1;
        d.sr1      = ir[8:6];
        d.sr2_used = ~ir[5];
        d.sr2      = ir[5] ? '0 : ir[2:0];
        d.dr_we    = 1'b1;
        d.dr       = ir[11:9];
      end
      OP_LDB, OP_LDW, OP_SHF: begin
        d.sr1_used = 1'b1;
        d.sr1      = ir[8:6];
        d.dr_we    = 1'b1;
        d.dr       = ir[11:9];
      end
      OP_JMP: begin
        d.sr1_used = 1'b1;
        d.sr1      = ir[8:6];
      end
      OP_JSR: begin
        // JSRR (bit11=0) reads its base register; JSR is PC-relative.
        d.sr1_used = ~ir[11];
        d.sr1      = ir[11] ? '0 : ir[8:6];
        d.dr_we    = 1'b1;
        d.dr       = LINK_REG;
      end
      OP_STB, OP_STW: begin
        d.sr1_used = 1'b1;
        d.sr1      = ir[8:6];
        d.sr2_used = 1'b1;
        d.sr2      = ir[11:9];
      end
      OP_LEA: begin
        d.dr_we = 1'b1;
        d.dr    = ir[11:9];
      end
      OP_TRAP: begin
        d.dr_we = 1'b1;
        d.dr    = LINK_REG;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm5(input logic [IMM5_W-1:0] v);
    return {{(DATA_W-IMM5_W){v[IMM5_W-1]}}, v};
  endfunction

endpackage

// File: rtl/scoreboard.sv
// Register busy tracking with set-over-clear priority and issue hazard detection.
module scoreboard
  import lc3b_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_W-1:0]    set_idx,
  input  logic                wb_clr,
  input  logic [REG_W-1:0]    wb_idx,
  input  logic                kill_clr,
  input  logic [REG_W-1:0]    kill_idx,
  input  logic                sr1_used,
  input  logic [REG_W-1:0]    sr1,
  input  logic                sr2_used,
  input  logic [REG_W-1:0]    sr2,
  input  logic                dr_used,
  input  logic [REG_W-1:0]    dr,
  output logic                hazard_c,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] live;
  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    wb_mask  = '0;
    clr_mask = '0;
    set_mask = '0;
    if (wb_clr)   wb_mask[wb_idx]    = 1'b1;
    clr_mask = wb_mask;
    if (kill_clr) clr_mask[kill_idx] = 1'b1;
    if (set_en)   set_mask[set_idx]  = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
  end

  // A register being written back this cycle no longer blocks issue.
  always_comb begin
    live     = busy & ~wb_mask;
    hazard_c = (sr1_used & live[sr1]) |
               (sr2_used & live[sr2]) |
               (dr_used  & live[dr]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/decode_stage.sv
// LC-3b decode stage: source decode, register read with writeback forwarding,
// scoreboard interlock and a single registered slot towards execute.
module decode_stage
  import lc3b_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ir,
  input  logic [DATA_W-1:0] in_pc,
  output logic [REG_W-1:0]  rf_sr1,
  output logic [REG_W-1:0]  rf_sr2,
  input  logic [DATA_W-1:0] rf_sr1_data,
  input  logic [DATA_W-1:0] rf_sr2_data,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_dr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ir,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [REG_W-1:0]  out_dr,
  output logic              out_dr_we
);

  dec_t              dec_c;
  logic [DATA_W-1:0] opa_c;
  logic [DATA_W-1:0] opb_c;
  logic              hazard_c;
  logic              accept_c;
  logic              kill_c;
  issue_t            issue_c;
  issue_t            out_q;
  logic              valid_q;

  assign dec_c  = decode(in_ir);
  assign rf_sr1 = dec_c.sr1;
  assign rf_sr2 = dec_c.sr2;

  // Operand select: writeback bypass for used sources, immediate when SR2 is unused.
  always_comb begin
    opa_c = '0;
    opb_c = sext_imm5(in_ir[IMM5_W-1:0]);
    if (dec_c.sr1_used)
      opa_c = (wb_we && (wb_dr == dec_c.sr1)) ? wb_data : rf_sr1_data;
    if (dec_c.sr2_used)
      opb_c = (wb_we && (wb_dr == dec_c.sr2)) ? wb_data : rf_sr2_data;
  end

  always_comb begin
    issue_c.ir    = in_ir;
    issue_c.pc    = in_pc;
    issue_c.a     = opa_c;
    issue_c.b     = opb_c;
    issue_c.dr    = dec_c.dr;
    issue_c.dr_we = dec_c.dr_we;
  end

  assign in_ready = ~hazard_c & ~flush & (~valid_q | out_ready);
  assign accept_c = in_valid & in_ready;
  assign kill_c   = flush & valid_q & out_q.dr_we;

  scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept_c & dec_c.dr_we),
    .set_idx  (dec_c.dr),
    .wb_clr   (wb_we),
    .wb_idx   (wb_dr),
    .kill_clr (kill_c),
    .kill_idx (out_q.dr),
    .sr1_used (dec_c.sr1_used),
    .sr1      (dec_c.sr1),
    .sr2_used (dec_c.sr2_used),
    .sr2      (dec_c.sr2),
    .dr_used  (dec_c.dr_we),
    .dr       (dec_c.dr),
    .hazard_c (hazard_c),
    .busy     ()
  );

  // Output slot: flush kills, accept loads, a consumed entry without refill empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept_c) begin
      valid_q <= 1'b1;
      out_q   <= issue_c;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_ir    = out_q.ir;
  assign out_pc    = out_q.pc;
  assign out_a     = out_q.a;
  assign out_b     = out_q.b;
  assign out_dr    = out_q.dr;
  assign out_dr_we = out_q.dr_we;

endmodule
